// File: rtl/jt10_adpcm_gain_if.sv
// Sample stream, register-write bus and gained L/R outputs of the ADPCM-A level/pan stage.
// The master side feeds channel slots and register writes; the slave side is the gain stage.
interface jt10_adpcm_gain_if;
    logic        cen;
    logic [5:0]  cur_ch;
    logic [15:0] pcm_in;
    logic [5:0]  atl;
    logic        up_wr;
    logic [2:0]  up_addr;
    logic [7:0]  up_din;
    logic [15:0] pcm_l;
    logic [15:0] pcm_r;
    logic [5:0]  out_ch;

    modport master (
        output cen, cur_ch, pcm_in, atl, up_wr, up_addr, up_din,
        input  pcm_l, pcm_r, out_ch
    );

    modport slave (
        input  cen, cur_ch, pcm_in, atl, up_wr, up_addr, up_din,
        output pcm_l, pcm_r, out_ch
    );
endinterface

// File: rtl/jt10_adpcm_gain.sv
// ADPCM-A per-channel level and pan: 3-stage exponential gain with L/R split and channel tag.
// Define JT10_ADPCM_GAIN_ROUND_EN to round the mantissa product half up instead of truncating.
module jt10_adpcm_gain (
    input  logic               clk,
    input  logic               rst_n,
    jt10_adpcm_gain_if.slave   bus
);

    // Per-channel {pan_l, pan_r, -, lvl[4:0]}, flattened for the S1 read mux
    logic [47:0] cfg_flat;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_cfg
            logic [7:0] cfg_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cfg_reg <= '0;
                else if (bus.up_wr && bus.up_addr == 3'(gi))
                    cfg_reg <= bus.up_din;
            end
            assign cfg_flat[gi*8 +: 8] = cfg_reg;
        end
    endgenerate

    // S1 channel decode and attenuation
    logic       ch_valid;
    logic [2:0] ch_idx;
    logic [7:0] ch_cfg;
    logic [6:0] att_next;

    always_comb begin
        ch_idx = '0;
        for (int i = 0; i < 6; i++)
            if (bus.cur_ch[i]) ch_idx = 3'(i);
        ch_valid = $onehot(bus.cur_ch);
        ch_cfg   = cfg_flat[{ch_idx, 3'b000} +: 8];
        att_next = 7'(6'd63 - bus.atl) + 7'(5'd31 - ch_cfg[4:0]);
    end

    logic signed [15:0] s1_pcm_reg;
    logic [6:0]         s1_att_reg;
    logic [1:0]         s1_pan_reg;
    logic [5:0]         s1_ch_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_pcm_reg <= '0;
            s1_att_reg <= '0;
            s1_pan_reg <= '0;
            s1_ch_reg  <= '0;
        end else if (bus.cen) begin
            if (ch_valid) begin
                s1_pcm_reg <= $signed(bus.pcm_in);
                s1_att_reg <= att_next;
                s1_pan_reg <= ch_cfg[7:6];
                s1_ch_reg  <= bus.cur_ch;
            end else begin
                s1_pcm_reg <= '0;
                s1_att_reg <= '0;
                s1_pan_reg <= '0;
                s1_ch_reg  <= '0;
            end
        end
    end

    // S2: fractional 0.75 dB steps via mantissa ROM
    logic [8:0]         mant;
    logic signed [24:0] prod;
    logic signed [24:0] prod_adj;
    logic signed [16:0] scaled_next;

    always_comb begin
        case (s1_att_reg[2:0])
            3'd0:    mant = 9'd256;
            3'd1:    mant = 9'd235;
            3'd2:    mant = 9'd215;
            3'd3:    mant = 9'd197;
            3'd4:    mant = 9'd181;
            3'd5:    mant = 9'd166;
            3'd6:    mant = 9'd152;
            default: mant = 9'd140;
        endcase
        prod = 25'(s1_pcm_reg) * $signed(25'({1'b0, mant}));
`ifdef JT10_ADPCM_GAIN_ROUND_EN
        prod_adj = prod + 25'sd128;
`else
        prod_adj = prod;
`endif
        scaled_next = 17'(prod_adj >>> 8);
    end

    logic signed [16:0] s2_scaled_reg;
    logic [3:0]         s2_shift_reg;
    logic [1:0]         s2_pan_reg;
    logic [5:0]         s2_ch_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_scaled_reg <= '0;
            s2_shift_reg  <= '0;
            s2_pan_reg    <= '0;
            s2_ch_reg     <= '0;
        end else if (bus.cen) begin
            s2_scaled_reg <= scaled_next;
            s2_shift_reg  <= s1_att_reg[6:3];
            s2_pan_reg    <= s1_pan_reg;
            s2_ch_reg     <= s1_ch_reg;
        end
    end

    // S3: 6 dB steps as arithmetic shift, then clamp to 16 bits
    logic signed [16:0] shifted_wide;
    logic [15:0]        shifted_sat;

    always_comb begin
        shifted_wide = s2_scaled_reg >>> s2_shift_reg;
        if (shifted_wide[16] != shifted_wide[15])
            shifted_sat = {shifted_wide[16], {15{~shifted_wide[16]}}};
        else
            shifted_sat = shifted_wide[15:0];
    end

    logic [15:0] pcm_l_reg;
    logic [15:0] pcm_r_reg;
    logic [5:0]  out_ch_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_l_reg  <= '0;
            pcm_r_reg  <= '0;
            out_ch_reg <= '0;
        end else if (bus.cen) begin
            pcm_l_reg  <= s2_pan_reg[1] ? shifted_sat : 16'd0;
            pcm_r_reg  <= s2_pan_reg[0] ? shifted_sat : 16'd0;
            out_ch_reg <= s2_ch_reg;
        end
    end

    assign bus.pcm_l  = pcm_l_reg;
    assign bus.pcm_r  = pcm_r_reg;
    assign bus.out_ch = out_ch_reg;

endmodule

// File: tb/tb_jt10_adpcm_gain.sv
// Bench for jt10_adpcm_gain: directed gain/pan cases then random traffic against an arithmetic model.
// The model follows JT10_ADPCM_GAIN_ROUND_EN the same way the design build does.
module tb_jt10_adpcm_gain;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jt10_adpcm_gain_if bus ();

    jt10_adpcm_gain dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic [5:0]  ch;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    logic [7:0] m_cfg [6];
    exp_t pipe [$];
    exp_t cur_exp;
    int   mant_tab [8] = '{256, 235, 215, 197, 181, 166, 152, 140};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    // Gain = mantissa/256 * 2^-(att/8), pan selects each side
    function automatic exp_t model_sample(input logic [5:0] ch, input logic [15:0] pcm,
                                          input logic [5:0] a);
        exp_t       e;
        int         idx, att, prod, scaled, shifted;
        logic [7:0] c;
        e = '0;
        if ($countones(ch) != 1) return e;
        idx = 0;
        for (int i = 0; i < 6; i++) if (ch[i]) idx = i;
        c = m_cfg[idx];
        att = (63 - int'(a)) + (31 - int'(c[4:0]));
        prod = int'($signed(pcm)) * mant_tab[att % 8];
`ifdef JT10_ADPCM_GAIN_ROUND_EN
        scaled = floor_div(prod + 128, 256);
`else
        scaled = floor_div(prod, 256);
`endif
        shifted = floor_div(scaled, 1 << (att / 8));
        if (shifted > 32767) shifted = 32767;
        if (shifted < -32768) shifted = -32768;
        e.ch = ch;
        e.l  = c[7] ? 16'(shifted) : 16'd0;
        e.r  = c[6] ? 16'(shifted) : 16'd0;
        return e;
    endfunction

    // One clk cycle: drive at negedge, update model at posedge, compare at next negedge
    task automatic step(input logic c, input logic [5:0] ch, input logic [15:0] pcm,
                        input logic [5:0] a, input logic w, input logic [2:0] ad,
                        input logic [7:0] d);
        bus.cen = c; bus.cur_ch = ch; bus.pcm_in = pcm; bus.atl = a;
        bus.up_wr = w; bus.up_addr = ad; bus.up_din = d;
        @(posedge clk);
        if (c) begin
            pipe.push_back(model_sample(ch, pcm, a));
            cur_exp = pipe.pop_front();
        end
        if (w && ad < 3'd6) m_cfg[ad] = d;
        @(negedge clk);
        check("pcm_l", 32'(bus.pcm_l), 32'(cur_exp.l));
        check("pcm_r", 32'(bus.pcm_r), 32'(cur_exp.r));
        check("out_ch", 32'(bus.out_ch), 32'(cur_exp.ch));
        bus.cen = 1'b0;
        bus.up_wr = 1'b0;
    endtask

    task automatic tick(input logic [5:0] ch, input logic [15:0] pcm, input logic [5:0] a);
        step(1'b1, ch, pcm, a, 1'b0, 3'd0, 8'd0);
    endtask

    task automatic wr(input logic [2:0] ad, input logic [7:0] d);
        step(1'b0, 6'd0, 16'd0, 6'd63, 1'b1, ad, d);
    endtask

    task automatic run3(input logic [5:0] ch, input logic [15:0] pcm, input logic [5:0] a);
        tick(ch, pcm, a);
        tick(6'd0, 16'd0, a);
        tick(6'd0, 16'd0, a);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) m_cfg[i] = '0;
        pipe.delete();
        pipe.push_back('0);
        pipe.push_back('0);
        cur_exp = '0;
        #1;
        check("rst_pcm_l", 32'(bus.pcm_l), 32'd0);
        check("rst_pcm_r", 32'(bus.pcm_r), 32'd0);
        check("rst_out_ch", 32'(bus.out_ch), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [15:0] exp_round;
    logic [5:0]  rnd_ch;
    logic [5:0]  rnd_atl;
    logic [15:0] rnd_pcm;
    int          sel;

    initial begin
        bus.cen = 1'b0; bus.cur_ch = '0; bus.pcm_in = '0; bus.atl = 6'd63;
        bus.up_wr = 1'b0; bus.up_addr = '0; bus.up_din = '0;
        @(negedge clk);
        do_reset();

        // Muted after reset while channels cycle
        for (int i = 0; i < 12; i++) tick(6'(1 << (i % 6)), 16'h7abc, 6'd63);

        // Unity gain, then 6 dB down
        wr(3'd0, 8'hDF);
        run3(6'b000001, 16'h4000, 6'd63);
        check("unity_l", 32'(bus.pcm_l), 32'h4000);
        check("unity_r", 32'(bus.pcm_r), 32'h4000);
        check("unity_ch", 32'(bus.out_ch), 32'h01);
        wr(3'd0, 8'hD7);
        run3(6'b000001, 16'h4000, 6'd63);
        check("att8_l", 32'(bus.pcm_l), 32'h2000);

        // Fractional gain, att = 3
        wr(3'd0, 8'hDC);
        run3(6'b000001, 16'h4000, 6'd63);
        check("att3_l", 32'(bus.pcm_l), 32'd12608);
        check("att3_r", 32'(bus.pcm_r), 32'd12608);

        // Left-only pan on ch2
        wr(3'd2, 8'h9F);
        run3(6'b000100, 16'd1000, 6'd63);
        check("pan_l", 32'(bus.pcm_l), 32'd1000);
        check("pan_r", 32'(bus.pcm_r), 32'd0);
        check("pan_ch", 32'(bus.out_ch), 32'h04);

        // Maximum attenuation, including floor on a negative sample
        wr(3'd1, 8'hC0);
        run3(6'b000010, 16'h4000, 6'd0);
        check("att94_pos", 32'(bus.pcm_l), 32'd4);
        run3(6'b000010, 16'h8000, 6'd0);
        check("att94_neg", 32'(bus.pcm_r), 32'h0000FFF6);

        // Rounding mode on a tiny sample
`ifdef JT10_ADPCM_GAIN_ROUND_EN
        exp_round = 16'd1;
`else
        exp_round = 16'd0;
`endif
        wr(3'd3, 8'hDB);
        run3(6'b001000, 16'd1, 6'd63);
        check("round_l", 32'(bus.pcm_l), 32'(exp_round));

        // Write on the same edge ch0 is read: old level first, new level next slot
        wr(3'd0, 8'hDF);
        step(1'b1, 6'b000001, 16'h4000, 6'd63, 1'b1, 3'd0, 8'hD7);
        tick(6'b000001, 16'h4000, 6'd63);
        tick(6'd0, 16'd0, 6'd63);
        check("coll_old", 32'(bus.pcm_l), 32'h4000);
        tick(6'd0, 16'd0, 6'd63);
        check("coll_new", 32'(bus.pcm_l), 32'h2000);

        // Idle and non-one-hot slots
        run3(6'd0, 16'h1234, 6'd63);
        check("idle_ch", 32'(bus.out_ch), 32'd0);
        run3(6'b000011, 16'h1234, 6'd63);
        check("multi_l", 32'(bus.pcm_l), 32'd0);

        // Random traffic, with one reset mid-stream
        rnd_atl = 6'd63;
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) do_reset();
            sel = int'($urandom_range(0, 11));
            if (sel < 6)       rnd_ch = 6'(1 << sel);
            else if (sel == 6) rnd_ch = 6'd0;
            else if (sel == 7) rnd_ch = 6'($urandom);
            else               rnd_ch = 6'(1 << (n % 6));
            if ($urandom_range(0, 9) == 0) rnd_atl = 6'($urandom);
            case ($urandom_range(0, 7))
                0:       rnd_pcm = 16'h8000;
                1:       rnd_pcm = 16'h7FFF;
                default: rnd_pcm = 16'($urandom);
            endcase
            step(1'($urandom_range(0, 1)), rnd_ch, rnd_pcm, rnd_atl,
                 $urandom_range(0, 3) == 0, 3'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jt10_adpcm_gain.md
# jt10_adpcm_gain

Per-channel level and pan stage for the six ADPCM-A channels. It sits directly upstream of the ADPCM-A accumulator/interpolator. It takes the decoder's time-multiplexed 16-bit channel samples, applies global total level plus per-channel instrument level as an exponential gain, and splits each sample into left/right. The result is a 3-stage pipeline, with channel identity carried alongside.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cen  in  1  pipeline advance strobe (111 kHz, one channel slot per tick)
- cur_ch  in  6  one-hot channel of pcm_in this slot; all-zero = idle slot
- pcm_in  in  16  signed decoder sample for cur_ch
- atl  in  6  ADPCM-A total level; 63 = loudest
- up_wr  in  1  register write strobe; sampled on every clk, not gated by cen
- up_addr  in  3  channel 0..5; 6 and 7 are ignored
- up_din  in  8  bit7 = L enable, bit6 = R enable, bits4:0 = instrument level (31 = loudest), bit5 is ignored
- pcm_l  out  16  signed left sample
- pcm_r  out  16  signed right sample
- out_ch  out  6  one-hot channel of pcm_l/pcm_r (cur_ch delayed 3 cen)

## Operation
- Six per-channel registers, each {pan_l, pan_r, lvl[4:0]}. On reset all are 0: muted, maximum attenuation.
- On up_wr, the register at up_addr is written on that clk edge.
- Attenuation: att[6:0] = (63-atl) + (31-lvl), range 0..94. One step = 0.75 dB; 8 steps = 6 dB.
- Mantissa ROM indexed by att[2:0], 9-bit unsigned: 256, 235, 215, 197, 181, 166, 152, 140.
- S1, on cen:
  - latch pcm_in;
  - encode cur_ch to an index and read that channel's register;
  - sample atl and compute att;
  - latch pan bits and cur_ch.
  - If cur_ch is all-zero or not one-hot, latch a zero sample, pan 00 and ch 0.
- S2, on cen: prod = pcm_in × mant, signed 16×unsigned 9 into 25 bits; scaled = prod >>> 8, 17 bits. Keep att[6:3] and pan.
- S3, on cen:
  - shifted = scaled >>> att[6:3] (arithmetic shift, 0..11), saturated to 16 bits;
  - pcm_l = pan_l ? shifted : 0; pcm_r = pan_r ? shifted : 0;
  - out_ch = S2 channel.
- Arithmetic shifts floor toward −∞.

## Timing
- Latency: a sample presented with cen at tick n appears on pcm_l/pcm_r/out_ch after the cen edge of tick n+2, i.e. 3 cen ticks.
- Outputs are held between cen ticks.
- Reset values: pcm_l = 0, pcm_r = 0, out_ch = 0. All pipeline registers, including the channel tags, clear asynchronously.
- Reset mid-operation: all in-flight samples are discarded and the registers return to the muted state.
- Without cen no stage advances. up_wr still writes.
- A write to channel k on the same edge that S1 reads channel k: S1 uses the old value, and the new value applies from the next slot of k.
- A change of atl affects only samples entering S1 after the change. In-flight samples keep the att they latched.
- up_addr 6 or 7: the write is dropped and no register changes.

## Configuration
- Macro `JT10_ADPCM_GAIN_ROUND_EN`.
- When defined, S2 computes scaled = (prod + 128) >>> 8, round half up.
- When undefined, S2 truncates: scaled = prod >>> 8.
- With gain ≤ 256 neither mode overflows 16 bits before the shift, so saturation in S3 is only defensive.

## Test plan
- Reset, then feed any samples with cur_ch cycling → pcm_l = pcm_r = 0 throughout and out_ch follows cur_ch 3 cen later.
- atl = 63, ch0 = {L=1, R=1, lvl=31}, pcm_in = 0x4000 on cur_ch = 000001 → after 3 cen: pcm_l = pcm_r = 0x4000, out_ch = 000001. With lvl = 23 (att = 8) → 0x2000.
- Fractional gain: att = 3 (lvl = 28), pcm_in = 0x4000 → 12608 on both outputs.
- Pan: ch2 = {L=1, R=0, lvl=31}, pcm_in = 1000 on cur_ch = 000100 → pcm_l = 1000, pcm_r = 0.
- Maximum attenuation, atl = 0 and lvl = 0 (att = 94):
  - pcm_in = 0x4000 → 4;
  - pcm_in = −32768 → −10 (floor rounding).
- Macro on vs off: att = 4 (lvl = 27), pcm_in = 1 → outputs 1 with `JT10_ADPCM_GAIN_ROUND_EN`, 0 without.
- Write collision: write ch0 lvl = 23 on the same clk edge as ch0's S1 cen → that sample uses lvl = 31 and ch0's next slot uses att = 8.
- Idle slot: cur_ch = 0 → zero outputs and out_ch = 0 three cen later.
